// File: rtl/rv_pkg.sv
// Shared encodings for the writeback stage: result-source select, load types and FSM states.
package rv_pkg;

    typedef enum logic [1:0] {
        WB_NPC = 2'b00,
        WB_ALU = 2'b01,
        WB_MEM = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: upstream instruction handshake, memory read response and register-file write port.
interface wb_stage_if #(
    parameter int N    = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    wb_sel;
    logic [N-1:0]  alu_res;
    logic [N-1:0]  npc;
    logic [N-1:0]  imm;
    logic [2:0]    ld_funct3;
    logic [AW-1:0] rd;
    logic          rd_we;
    logic          mem_rvalid;
    logic [N-1:0]  mem_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          misalign;

    modport master (
        output in_valid, wb_sel, alu_res, npc, imm, ld_funct3, rd, rd_we, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, misalign
    );

    modport slave (
        input  in_valid, wb_sel, alu_res, npc, imm, ld_funct3, rd, rd_we, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, misalign
    );

endinterface

// File: rtl/wb_ld_align.sv
// Load data alignment: shifts the memory word down by the byte offset and sign/zero-extends it.
module wb_ld_align
    import rv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]           data,
    input  logic [$clog2(N/8)-1:0] offset,
    input  logic [2:0]             funct3,
    output logic [N-1:0]           value,
    output logic                   misaligned
);

    logic [N-1:0] shifted;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        shifted    = data >> {offset, 3'b000};
        value      = '0;
        misaligned = 1'b0;
        case (funct3)
            LD_LB:  value = N'($signed(shifted[7:0]));
            LD_LBU: value = N'(shifted[7:0]);
            LD_LH: begin
                value      = N'($signed(shifted[15:0]));
                misaligned = offset[0];
            end
            LD_LHU: begin
                value      = N'(shifted[15:0]);
                misaligned = offset[0];
            end
            LD_LW: begin
                value      = N'($signed(shifted[31:0]));
                misaligned = |offset[1:0];
            end
            // LWU and LD only exist on a 64-bit datapath.
            LD_LWU: begin
                if (N == 64) begin
                    value      = N'(shifted[31:0]);
                    misaligned = |offset[1:0];
                end else begin
                    misaligned = 1'b1;
                end
            end
            LD_LD: begin
                if (N == 64) begin
                    value      = shifted;
                    misaligned = |offset;
                end else begin
                    misaligned = 1'b1;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the result, waits for load data if needed, and drives one registered RF write.
// Optional feature macro: WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output.
module wb_stage
    import rv_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    localparam int AW = $clog2(NREG);
    localparam int OB = $clog2(N / 8);

    wb_state_e     state_q, state_d;
    wb_sel_e       sel_q, cur_sel;
    logic [AW-1:0] rd_q, cur_rd;
    logic          rd_we_q, cur_rd_we;
    logic [2:0]    f3_q, cur_f3;
    logic [OB-1:0] off_q, cur_off;
    logic [N-1:0]  op_q, cur_op, live_op;
    logic          in_wait, accept, commit, is_load, ld_mis, mis, wr;
    logic [N-1:0]  ld_value, result;

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_wait      = (state_q == WAIT_MEM);

    always_comb begin
        live_op = bus.npc;
        case (wb_sel_e'(bus.wb_sel))
            WB_ALU:  live_op = bus.alu_res;
            WB_IMM:  live_op = bus.imm;
            default: live_op = bus.npc;
        endcase
    end

    // While waiting on memory the upstream bus may change, so commit from the captured fields.
    assign cur_sel   = in_wait ? sel_q   : wb_sel_e'(bus.wb_sel);
    assign cur_rd    = in_wait ? rd_q    : bus.rd;
    assign cur_rd_we = in_wait ? rd_we_q : bus.rd_we;
    assign cur_f3    = in_wait ? f3_q    : bus.ld_funct3;
    assign cur_off   = in_wait ? off_q   : bus.alu_res[OB-1:0];
    assign cur_op    = in_wait ? op_q    : live_op;

    wb_ld_align #(.N(N)) u_ld_align (
        .data       (bus.mem_rdata),
        .offset     (cur_off),
        .funct3     (cur_f3),
        .value      (ld_value),
        .misaligned (ld_mis)
    );

    assign is_load = (cur_sel == WB_MEM);
    assign result  = is_load ? ld_value : cur_op;
    assign mis     = is_load && ld_mis;
    assign wr      = cur_rd_we && (cur_rd != '0) && !mis;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_load || bus.mem_rvalid) commit  = 1'b1;
                    else                            state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: capture registers carry no reset; they are only read in WAIT_MEM, which an accept always precedes.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_q   <= wb_sel_e'(bus.wb_sel);
            rd_q    <= bus.rd;
            rd_we_q <= bus.rd_we;
            f3_q    <= bus.ld_funct3;
            off_q   <= bus.alu_res[OB-1:0];
            op_q    <= live_op;
        end
    end

    // Address and data move only on a real write so they hold the last committed value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.misalign <= 1'b0;
        end else begin
            bus.rf_we    <= commit && wr;
            bus.misalign <= commit && mis;
            if (commit && wr) begin
                bus.rf_waddr <= cur_rd;
                bus.rf_wdata <= result;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retire_cnt <= '0;
        else if (commit) retire_cnt <= retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a byte-level load model.
module tb_wb_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if #(.N(32), .NREG(32)) b();
    wb_stage_if #(.N(64), .NREG(32)) b64();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt, retire_cnt64;
    wb_stage #(.N(32), .NREG(32)) dut   (.clk(clk), .rst(rst), .bus(b),   .retire_cnt(retire_cnt));
    wb_stage #(.N(64), .NREG(32)) dut64 (.clk(clk), .rst(rst), .bus(b64), .retire_cnt(retire_cnt64));
`else
    wb_stage #(.N(32), .NREG(32)) dut   (.clk(clk), .rst(rst), .bus(b));
    wb_stage #(.N(64), .NREG(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    logic [63:0] exp_retire;
    logic [63:0] exp_retire64;

    // ---------------- reference model ----------------
    function automatic int ld_size(input int n, input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            3'd3:       return (n == 64) ? 8 : 0;
            3'd6:       return (n == 64) ? 4 : 0;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ld_mis(input int n, input int off, input logic [2:0] f3);
        int sz = ld_size(n, f3);
        return (sz == 0) || (off % sz != 0);
    endfunction

    function automatic logic [63:0] ld_val(input int n, input logic [63:0] data, input int off,
                                           input logic [2:0] f3);
        int sz = ld_size(n, f3);
        logic [63:0] raw, mask;
        if (sz == 0) return 64'd0;
        raw = data >> (8 * off);
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            raw  = raw & mask;
            if (f3[2] == 1'b0 && raw[8*sz-1]) raw = raw | ~mask;
        end
        if (n == 32) raw = raw & 64'h0000_0000_FFFF_FFFF;
        return raw;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] npc,
                             input logic [31:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                             input logic we);
        b.wb_sel = sel; b.alu_res = alu; b.npc = npc; b.imm = imm;
        b.ld_funct3 = f3; b.rd = rd; b.rd_we = we;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_instr(2'b00, 0, 0, 0, 3'd0, 5'd0, 1'b0);
        b.in_valid = 0; b.mem_rvalid = 0; b.mem_rdata = 0;
        b64.in_valid = 0; b64.wb_sel = 0; b64.alu_res = 0; b64.npc = 0; b64.imm = 0;
        b64.ld_funct3 = 0; b64.rd = 0; b64.rd_we = 0; b64.mem_rvalid = 0; b64.mem_rdata = 0;
        rst = 1'b1;
        #12;
        n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", b.in_ready); end
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", b.rf_we); end
        n_tests++; if (b.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got=%h exp=0", b.rf_waddr); end
        n_tests++; if (b.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", b.rf_wdata); end
        n_tests++; if (b.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", b.misalign); end
        n_tests++; if (b64.rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_wdata64 got=%h exp=0", b64.rf_wdata); end
`ifdef WB_RETIRE_CNT_EN
        n_tests++; if (retire_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
`endif
        @(negedge clk) rst = 1'b0;
        last_waddr = 0; last_wdata = 0; exp_retire = 0; exp_retire64 = 0;
        step();
    endtask

    task automatic test_alu();
        set_instr(2'b01, 32'h1234, $urandom, $urandom, 3'd0, 5'd5, 1'b1);
        b.in_valid = 1;
        n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got=%b exp=1", b.in_ready); end
        step();
        b.in_valid = 0;
        exp_retire++;
        n_tests++; if (b.rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%b exp=1", b.rf_we); end
        n_tests++; if (b.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_waddr got=%0d exp=5", b.rf_waddr); end
        n_tests++; if (b.rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata got=%h exp=00001234", b.rf_wdata); end
        last_waddr = 5'd5; last_wdata = 32'h1234;
        step();
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop got=%b exp=0", b.rf_we); end
        n_tests++; if (b.rf_wdata !== last_wdata) begin n_fail++; $display("FAIL alu_hold got=%h exp=%h", b.rf_wdata, last_wdata); end
    endtask

    task automatic test_lb_wait();
        set_instr(2'b10, {$urandom_range(0, 1023), 2'b11}, $urandom, $urandom, LD_LB, 5'd7, 1'b1);
        b.in_valid = 1; b.mem_rvalid = 0;
        step();
        b.in_valid = 0;
        set_instr(2'b01, 32'h0, $urandom, $urandom, LD_LW, 5'd12, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            n_tests++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_ready cyc=%0d got=%b exp=0", k, b.in_ready); end
            n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL lb_early_we cyc=%0d got=%b exp=0", k, b.rf_we); end
            b.mem_rvalid = (k == 3);
            b.mem_rdata  = (k == 3) ? 32'h8000_0000 : $urandom;
            step();
        end
        b.mem_rvalid = 0;
        exp_retire++;
        n_tests++; if (b.rf_we !== 1'b1) begin n_fail++; $display("FAIL lb_we got=%b exp=1", b.rf_we); end
        n_tests++; if (b.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL lb_waddr got=%0d exp=7", b.rf_waddr); end
        n_tests++; if (b.rf_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wdata got=%h exp=ffffff80", b.rf_wdata); end
        n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_back got=%b exp=1", b.in_ready); end
        last_waddr = 5'd7; last_wdata = 32'hFFFF_FF80;
    endtask

    task automatic test_lhu_misalign();
        set_instr(2'b10, 32'h0000_0101, $urandom, $urandom, LD_LHU, 5'd9, 1'b1);
        b.in_valid = 1; b.mem_rvalid = 1; b.mem_rdata = $urandom;
        step();
        b.in_valid = 0; b.mem_rvalid = 0;
        exp_retire++;
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL lhu_we got=%b exp=0", b.rf_we); end
        n_tests++; if (b.misalign !== 1'b1) begin n_fail++; $display("FAIL lhu_mis got=%b exp=1", b.misalign); end
        n_tests++; if (b.rf_waddr !== last_waddr) begin n_fail++; $display("FAIL lhu_waddr_hold got=%0d exp=%0d", b.rf_waddr, last_waddr); end
        step();
        n_tests++; if (b.misalign !== 1'b0) begin n_fail++; $display("FAIL lhu_mis_pulse got=%b exp=0", b.misalign); end
    endtask

    task automatic test_imm_rd0();
`ifdef WB_RETIRE_CNT_EN
        n_tests++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL imm_retire_pre got=%0d exp=%0d", retire_cnt, exp_retire); end
`endif
        set_instr(2'b11, $urandom, $urandom, 32'hABC, 3'd0, 5'd0, 1'b1);
        b.in_valid = 1;
        step();
        b.in_valid = 0;
        exp_retire++;
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL imm_rd0_we got=%b exp=0", b.rf_we); end
        n_tests++; if (b.rf_wdata !== last_wdata) begin n_fail++; $display("FAIL imm_rd0_hold got=%h exp=%h", b.rf_wdata, last_wdata); end
`ifdef WB_RETIRE_CNT_EN
        n_tests++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL imm_retire got=%0d exp=%0d", retire_cnt, exp_retire); end
`endif
        step();
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL imm_rd0_we2 got=%b exp=0", b.rf_we); end
    endtask

    task automatic test_reset_in_wait();
        set_instr(2'b10, 32'h100, $urandom, $urandom, LD_LW, 5'd3, 1'b1);
        b.in_valid = 1; b.mem_rvalid = 0;
        step();
        b.in_valid = 0;
        step();
        n_tests++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL rw_wait got=%b exp=0", b.in_ready); end
        rst = 1'b1;
        #2;
        n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL rw_async_idle got=%b exp=1", b.in_ready); end
        n_tests++; if (b.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rw_async_wdata got=%h exp=0", b.rf_wdata); end
        n_tests++; if (b.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL rw_async_waddr got=%0d exp=0", b.rf_waddr); end
        @(negedge clk) rst = 1'b0;
        last_waddr = 0; last_wdata = 0; exp_retire = 0; exp_retire64 = 0;
        b.mem_rvalid = 1; b.mem_rdata = $urandom;
        step();
        b.mem_rvalid = 0;
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL rw_late_we got=%b exp=0", b.rf_we); end
        n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL rw_late_idle got=%b exp=1", b.in_ready); end
        step();
        n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL rw_late_we2 got=%b exp=0", b.rf_we); end
        n_tests++; if (b.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rw_late_wdata got=%h exp=0", b.rf_wdata); end
`ifdef WB_RETIRE_CNT_EN
        n_tests++; if (retire_cnt !== 64'd0) begin n_fail++; $display("FAIL rw_retire got=%0d exp=0", retire_cnt); end
`endif
    endtask

    // One random instruction per cycle; loads always get their data immediately.
    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [1:0] sel; logic [2:0] f3; logic [4:0] rd; logic [31:0] alu, npc, imm, data;
            logic [63:0] ev; bit em, ewe; int off, sz;
            sel = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 31)); alu = $urandom; npc = $urandom; imm = $urandom; data = $urandom;
            off = $urandom_range(0, 3); sz = ld_size(32, f3);
            if (sz > 0 && $urandom_range(0, 3) != 0) off = off - off % sz;
            alu[1:0] = off[1:0];
            set_instr(sel, alu, npc, imm, f3, rd, 1'b1);
            b.in_valid = 1; b.mem_rvalid = 1; b.mem_rdata = data;
            n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, b.in_ready); end
            em = (sel == 2'b10) && ld_mis(32, off, f3);
            ev = (sel == 2'b00) ? {32'd0, npc} : (sel == 2'b01) ? {32'd0, alu} :
                 (sel == 2'b11) ? {32'd0, imm} : ld_val(32, {32'd0, data}, off, f3);
            ewe = (rd != 0) && !em;
            step();
            exp_retire++;
            n_tests++; if (b.rf_we !== ewe) begin n_fail++; $display("FAIL b2b_we i=%0d got=%b exp=%b", i, b.rf_we, ewe); end
            n_tests++; if (b.misalign !== em) begin n_fail++; $display("FAIL b2b_mis i=%0d got=%b exp=%b", i, b.misalign, em); end
            if (ewe) begin last_waddr = rd; last_wdata = ev[31:0]; end
            n_tests++; if (b.rf_wdata !== last_wdata || b.rf_waddr !== last_waddr) begin
                n_fail++; $display("FAIL b2b_data i=%0d got=%0d:%h exp=%0d:%h", i, b.rf_waddr, b.rf_wdata, last_waddr, last_wdata);
            end
        end
        b.in_valid = 0; b.mem_rvalid = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            logic [1:0] sel; logic [2:0] f3; logic [4:0] rd; logic we; logic [31:0] alu, npc, imm, data;
            logic [63:0] ev; bit em, ewe; int off, sz, dly;
            sel = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            we = ($urandom_range(0, 4) != 0);
            alu = $urandom; npc = $urandom; imm = $urandom; data = $urandom;
            off = $urandom_range(0, 3); sz = ld_size(32, f3);
            if (sz > 0 && $urandom_range(0, 3) != 0) off = off - off % sz;
            alu[1:0] = off[1:0];
            dly = (sel == 2'b10) ? $urandom_range(0, 3) : 0;
            set_instr(sel, alu, npc, imm, f3, rd, we);
            b.in_valid   = 1;
            b.mem_rvalid = (sel == 2'b10) ? (dly == 0) : 1'($urandom_range(0, 1));
            b.mem_rdata  = (sel == 2'b10 && dly == 0) ? data : $urandom;
            em  = (sel == 2'b10) && ld_mis(32, off, f3);
            ev  = (sel == 2'b00) ? {32'd0, npc} : (sel == 2'b01) ? {32'd0, alu} :
                  (sel == 2'b11) ? {32'd0, imm} : ld_val(32, {32'd0, data}, off, f3);
            ewe = we && (rd != 0) && !em;
            step();
            b.in_valid = 0;
            set_instr(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            for (int k = 1; k <= dly; k++) begin
                n_tests++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_wait i=%0d k=%0d got=%b exp=0", i, k, b.in_ready); end
                n_tests++; if (b.rf_we !== 1'b0) begin n_fail++; $display("FAIL rnd_early_we i=%0d k=%0d got=%b exp=0", i, k, b.rf_we); end
                b.mem_rvalid = (k == dly);
                b.mem_rdata  = (k == dly) ? data : $urandom;
                step();
            end
            b.mem_rvalid = 0;
            exp_retire++;
            n_tests++; if (b.rf_we !== ewe) begin n_fail++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, b.rf_we, ewe); end
            n_tests++; if (b.misalign !== em) begin n_fail++; $display("FAIL rnd_mis i=%0d got=%b exp=%b", i, b.misalign, em); end
            if (ewe) begin last_waddr = rd; last_wdata = ev[31:0]; end
            n_tests++; if (b.rf_wdata !== last_wdata || b.rf_waddr !== last_waddr) begin
                n_fail++; $display("FAIL rnd_data i=%0d got=%0d:%h exp=%0d:%h", i, b.rf_waddr, b.rf_wdata, last_waddr, last_wdata);
            end
`ifdef WB_RETIRE_CNT_EN
            n_tests++; if (retire_cnt !== exp_retire) begin n_fail++; $display("FAIL rnd_retire i=%0d got=%0d exp=%0d", i, retire_cnt, exp_retire); end
`endif
            // A stray memory response with no load pending must do nothing.
            b.mem_rvalid = 1'($urandom_range(0, 1)); b.mem_rdata = $urandom;
            step();
            b.mem_rvalid = 0;
            n_tests++; if (b.rf_we !== 1'b0 || b.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rnd_idle i=%0d we=%b ready=%b exp we=0 ready=1", i, b.rf_we, b.in_ready);
            end
        end
    endtask

    task automatic test_n64();
        logic [63:0] last64 = 64'd0;
        b64.wb_sel = 2'b10; b64.ld_funct3 = LD_LWU; b64.rd = 5'd4; b64.rd_we = 1;
        b64.alu_res = {$urandom, 32'd4}; b64.mem_rvalid = 1; b64.mem_rdata = 64'hFFFF_FFFF_0000_0000;
        b64.in_valid = 1;
        step();
        b64.in_valid = 0; b64.mem_rvalid = 0;
        exp_retire64++;
        n_tests++; if (b64.rf_we !== 1'b1) begin n_fail++; $display("FAIL n64_lwu_we got=%b exp=1", b64.rf_we); end
        n_tests++; if (b64.rf_wdata !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++; $display("FAIL n64_lwu_wdata got=%h exp=00000000ffffffff", b64.rf_wdata);
        end
        last64 = 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3; logic [4:0] rd; logic [63:0] data, ev; bit em, ewe; int off, sz;
            f3 = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(1, 31)); data = {$urandom, $urandom};
            off = $urandom_range(0, 7); sz = ld_size(64, f3);
            if (sz > 0 && $urandom_range(0, 3) != 0) off = off - off % sz;
            b64.wb_sel = 2'b10; b64.ld_funct3 = f3; b64.rd = rd; b64.rd_we = 1;
            b64.alu_res = {$urandom, 29'($urandom), 3'(off)}; b64.mem_rvalid = 1; b64.mem_rdata = data;
            b64.in_valid = 1;
            em  = ld_mis(64, off, f3);
            ev  = ld_val(64, data, off, f3);
            ewe = !em;
            step();
            b64.in_valid = 0; b64.mem_rvalid = 0;
            exp_retire64++;
            n_tests++; if (b64.rf_we !== ewe || b64.misalign !== em) begin
                n_fail++; $display("FAIL n64_ctl i=%0d f3=%0d off=%0d we=%b mis=%b exp we=%b mis=%b", i, f3, off, b64.rf_we, b64.misalign, ewe, em);
            end
            if (ewe) last64 = ev;
            n_tests++; if (b64.rf_wdata !== last64) begin
                n_fail++; $display("FAIL n64_wdata i=%0d f3=%0d off=%0d got=%h exp=%h", i, f3, off, b64.rf_wdata, last64);
            end
        end
`ifdef WB_RETIRE_CNT_EN
        n_tests++; if (retire_cnt64 !== exp_retire64) begin n_fail++; $display("FAIL n64_retire got=%0d exp=%0d", retire_cnt64, exp_retire64); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_lb_wait();
        test_lhu_misalign();
        test_imm_rd0();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        test_n64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
